// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Program sequencer for the multicycle proc core. Owns the PC, fetches
// instruction words from a synchronous-read RAM, hands each instruction to the
// proc (proc_din / proc_run) and waits for proc_done before moving on. The
// single RAM port is shared between instruction fetch and the proc's ld/sd
// traffic. An instruction with opcode 4'b1111 stops the sequencer in HALT.
//
// Optional build macro: SINGLE_STEP_EN
//   When defined, an extra Step input is added. After every instruction the
//   sequencer parks in IDLE and runs exactly one further instruction per rising
//   edge of Step. Start is ignored in this build.
//
// Parameters
//   ADDR_W    RAM address width; the PC wraps modulo 2**ADDR_W (ADDR_W < 16)
//   RESET_PC  PC value loaded at reset
//
// Ports
//   Clock       in   system clock, all state on the rising edge
//   Resetn      in   asynchronous active-low reset
//   Start       in   level; the sequencer runs while high
//   Step        in   (SINGLE_STEP_EN only) one instruction per rising edge
//   mem_rdata   in   RAM read data, valid one cycle after mem_addr
//   mem_addr    out  RAM address (PC-derived, or proc address for ld/sd)
//   mem_wr      out  RAM write strobe (write data is the proc bus, external)
//   proc_addr   in   proc ADDR register
//   proc_store  in   proc store strobe
//   proc_done   in   proc Done
//   proc_run    out  proc Run
//   proc_din    out  instruction / immediate word to proc DIN
//   proc_mem    out  RAM data to the proc memory input (combinational)
//   pc          out  current PC
//   halted      out  high in HALT
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int                ADDR_W   = 7,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
`ifdef SINGLE_STEP_EN
    input  logic              Step,
`endif
    input  logic [15:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    input  logic [15:0]       proc_addr,
    input  logic              proc_store,
    input  logic              proc_done,
    output logic              proc_run,
    output logic [15:0]       proc_din,
    output logic [15:0]       proc_mem,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam logic [3:0] OP_MVI  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b1000;
    localparam logic [3:0] OP_SD   = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT_RD = 3'd2,
        IMM_RD  = 3'd3,
        ISSUE   = 3'd4,
        EXEC    = 3'd5,
        HALT    = 3'd6
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [15:0]       instr_reg, instr_next;
    logic [15:0]       imm_reg, imm_next;

    logic              is_mvi;
    logic              is_ldst;
    logic              is_sd;
    logic [ADDR_W-1:0] pc_plus1;
    logic              go;      // leave IDLE
    logic              resume;  // continue to FETCH after an instruction

    // Only the low ADDR_W bits of the proc address reach the RAM.
    logic unused_bits;

`ifdef SINGLE_STEP_EN
    logic step_prev_reg;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            step_prev_reg <= 1'b0;
        end else begin
            step_prev_reg <= Step;
        end
    end

    assign go          = Step & ~step_prev_reg;
    assign resume      = 1'b0;   // always park in IDLE between instructions
    assign unused_bits = ^{proc_addr[15:ADDR_W], Start};
`else
    assign go          = Start;
    // Start is re-examined on the way back to FETCH; low means park in IDLE.
    assign resume      = Start;
    assign unused_bits = ^proc_addr[15:ADDR_W];
`endif

    assign is_mvi   = (instr_reg[3:0] == OP_MVI);
    assign is_sd    = (instr_reg[3:0] == OP_SD);
    assign is_ldst  = (instr_reg[3:0] == OP_LD) || is_sd;
    assign pc_plus1 = pc_reg + ADDR_W'(1);

    // State register
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            instr_reg <= '0;
            imm_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            imm_reg   <= imm_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        imm_next   = imm_reg;
        case (state_reg)
            IDLE: begin
                if (go) state_next = FETCH;
            end
            FETCH: begin
                state_next = WAIT_RD;
            end
            WAIT_RD: begin
                instr_next = mem_rdata;
                if (mem_rdata[3:0] == OP_HALT) begin
                    state_next = HALT;
                end else if (mem_rdata[3:0] == OP_MVI) begin
                    state_next = IMM_RD;
                end else begin
                    state_next = ISSUE;
                end
            end
            IMM_RD: begin
                imm_next   = mem_rdata;
                state_next = ISSUE;
            end
            ISSUE: begin
                state_next = EXEC;
            end
            EXEC: begin
                // No timeout: a proc that never signals Done holds us here.
                if (proc_done) begin
                    pc_next    = pc_reg + (is_mvi ? ADDR_W'(2) : ADDR_W'(1));
                    state_next = resume ? FETCH : IDLE;
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs
    always_comb begin
        mem_addr = pc_reg;
        proc_din = '0;
        case (state_reg)
            WAIT_RD: begin
                // Start the immediate read as soon as the opcode is visible.
                if (mem_rdata[3:0] == OP_MVI) mem_addr = pc_plus1;
            end
            IMM_RD: begin
                mem_addr = pc_plus1;
            end
            ISSUE: begin
                proc_din = instr_reg;
            end
            EXEC: begin
                proc_din = is_mvi ? imm_reg : instr_reg;
                // The proc owns the RAM port for loads and stores.
                if (is_ldst) mem_addr = proc_addr[ADDR_W-1:0];
            end
            default: begin
                mem_addr = pc_reg;
            end
        endcase
    end

    assign proc_run = (state_reg == ISSUE) || (state_reg == EXEC);
    assign mem_wr   = proc_store && (state_reg == EXEC) && is_sd;
    assign proc_mem = mem_rdata;
    assign pc       = pc_reg;
    assign halted   = (state_reg == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Bench for fetch_sequencer. Provides a synchronous-read RAM and a scripted
// proc. The expected behaviour of each instruction (issued words, latency,
// next PC, RAM traffic) is derived from a program-level model kept in
// ref_mem: the word at the PC, its opcode and modulo-128 PC arithmetic.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam int AW = 7;

    logic          Clock = 1'b0;
    logic          Resetn;
    logic          Start;
    logic [15:0]   mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_wr;
    logic [15:0]   proc_addr;
    logic          proc_store;
    logic          proc_done;
    logic          proc_run;
    logic [15:0]   proc_din;
    logic [15:0]   proc_mem;
    logic [AW-1:0] pc;
    logic          halted;

    logic [15:0]   ram     [0:127];
    logic [15:0]   ref_mem [0:127];
    logic          bulk_load = 1'b0;
    logic [15:0]   wdata;

    logic [AW-1:0] exp_pc;
    bit            halt_seen;
    int            checks = 0;
    int            errors = 0;

    fetch_sequencer #(.ADDR_W(AW), .RESET_PC(7'd0)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .Start      (Start),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_wr     (mem_wr),
        .proc_addr  (proc_addr),
        .proc_store (proc_store),
        .proc_done  (proc_done),
        .proc_run   (proc_run),
        .proc_din   (proc_din),
        .proc_mem   (proc_mem),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 Clock = ~Clock;

    // Synchronous-read RAM; bulk_load copies the reference image in one cycle.
    always @(posedge Clock) begin
        if (bulk_load) begin
            for (int i = 0; i < 128; i++) ram[i] <= ref_mem[i];
        end else if (mem_wr) begin
            ram[mem_addr] <= wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic do_reset;
        Start      = 1'b0;
        proc_done  = 1'b0;
        proc_store = 1'b0;
        proc_addr  = 16'h0;
        wdata      = 16'h0;
        @(negedge Clock);
        Resetn    = 1'b0;
        bulk_load = 1'b1;
        @(negedge Clock);
        bulk_load = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        exp_pc = 7'd0;
    endtask

    // Runs one instruction from exp_pc. Call at a negedge just before the
    // clock edge that starts the fetch (Start sampled in IDLE, or Done in EXEC).
    task automatic do_instr(input int dly_in, input logic [15:0] paddr,
                            input logic [15:0] wd, input bit drop_start);
        logic [15:0]   instr, imm, want_din;
        logic [AW-1:0] npc, a, a1;
        bit            mvi, ld, sd;
        int            k, want_k, dly;
        instr    = ref_mem[exp_pc];
        mvi      = (instr[3:0] == 4'b0001);
        ld       = (instr[3:0] == 4'b1000);
        sd       = (instr[3:0] == 4'b1001);
        a1       = AW'((int'(exp_pc) + 1) % 128);
        imm      = ref_mem[a1];
        npc      = AW'((int'(exp_pc) + (mvi ? 2 : 1)) % 128);
        want_k   = mvi ? 4 : 3;
        want_din = mvi ? imm : instr;
        a        = paddr[AW-1:0];
        dly      = ((ld || sd) && dly_in < 1) ? 1 : dly_in;
        halt_seen = 1'b0;

        k = 0;
        do begin
            @(negedge Clock);
            proc_done = 1'b0;
            k++;
            if (k == 1) begin
                checks++;
                if (pc !== exp_pc || mem_addr !== exp_pc || proc_run !== 1'b0) begin
                    errors++;
                    $display("FAIL fetch_pc: pc=%0d mem_addr=%0d run=%b, required pc=mem_addr=%0d run=0",
                             pc, mem_addr, proc_run, exp_pc);
                end
            end
        end while (proc_run !== 1'b1 && halted !== 1'b1 && k < 12);

        if (instr[3:0] == 4'b1111) begin
            checks++;
            if (halted !== 1'b1 || proc_run !== 1'b0 || k != 3 || pc !== exp_pc) begin
                errors++;
                $display("FAIL halt_entry: halted=%b run=%b cycles=%0d pc=%0d, required 1 0 3 %0d",
                         halted, proc_run, k, pc, exp_pc);
            end
            halt_seen = 1'b1;
            $display("instr pc=%0d word=%h HALT", exp_pc, instr);
            return;
        end

        // ISSUE
        checks++;
        if (proc_run !== 1'b1 || halted !== 1'b0 || k != want_k) begin
            errors++;
            $display("FAIL issue_latency: run=%b halted=%b cycles=%0d, required run=1 halted=0 cycles=%0d",
                     proc_run, halted, k, want_k);
        end
        checks++;
        if (proc_din !== instr) begin
            errors++;
            $display("FAIL issue_din: got %h required %h", proc_din, instr);
        end
        // Done and store before EXEC must both be ignored.
        proc_done  = 1'b1;
        proc_store = 1'b1;
        proc_addr  = paddr;
        wdata      = wd;
        #1;
        checks++;
        if (mem_wr !== 1'b0) begin
            errors++;
            $display("FAIL store_outside_exec: mem_wr=%b required 0", mem_wr);
        end

        // First EXEC cycle
        @(negedge Clock);
        proc_done  = 1'b0;
        proc_store = 1'b0;
        checks++;
        if (proc_run !== 1'b1 || proc_din !== want_din || pc !== exp_pc) begin
            errors++;
            $display("FAIL exec_din: run=%b din=%h pc=%0d, required run=1 din=%h pc=%0d",
                     proc_run, proc_din, pc, want_din, exp_pc);
        end
        checks++;
        if ((ld || sd) ? (mem_addr !== a) : (mem_addr !== exp_pc)) begin
            errors++;
            $display("FAIL exec_addr: got %0d required %0d", mem_addr, (ld || sd) ? a : exp_pc);
        end
        if (sd) begin
            proc_store = 1'b1;
            #1;
            checks++;
            if (mem_wr !== 1'b1) begin
                errors++;
                $display("FAIL sd_wr: mem_wr=%b required 1", mem_wr);
            end
        end

        for (int i = 0; i < dly; i++) begin
            @(negedge Clock);
            if (sd && i == 0) begin
                proc_store = 1'b0;
                ref_mem[a] = wd;
                #1;
                checks++;
                if (mem_wr !== 1'b0) begin
                    errors++;
                    $display("FAIL sd_wr_pulse: mem_wr=%b required 0", mem_wr);
                end
            end
            if (ld && i == 0) begin
                checks++;
                if (proc_mem !== ref_mem[a]) begin
                    errors++;
                    $display("FAIL ld_data: proc_mem=%h required %h", proc_mem, ref_mem[a]);
                end
            end
            checks++;
            if (proc_run !== 1'b1 || pc !== exp_pc) begin
                errors++;
                $display("FAIL exec_hold: run=%b pc=%0d, required run=1 pc=%0d", proc_run, pc, exp_pc);
            end
        end

        proc_done = 1'b1;
        if (drop_start) Start = 1'b0;
        $display("instr pc=%0d word=%h din=%h exec_cycles=%0d next_pc=%0d",
                 exp_pc, instr, want_din, dly + 1, npc);
        exp_pc = npc;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0080;
        Resetn = 1'b0;
        do_reset;
        checks++;
        if (pc !== 7'd0 || mem_addr !== 7'd0 || proc_run !== 1'b0 || proc_din !== 16'h0 ||
            mem_wr !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: pc=%0d addr=%0d run=%b din=%h wr=%b halted=%b, required all zero",
                     pc, mem_addr, proc_run, proc_din, mem_wr, halted);
        end
        $display("reset pc=%0d run=%b halted=%b", pc, proc_run, halted);
    endtask

    // mv, mvi, sd, ld, halt, then a Resetn pulse out of HALT.
    task automatic test_program;
        for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0080;
        ref_mem[0]     = 16'h0080;
        ref_mem[1]     = 16'h0021;
        ref_mem[2]     = 16'h00A5;
        ref_mem[3]     = 16'h0029;
        ref_mem[4]     = 16'h0028;
        ref_mem[5]     = 16'h000F;
        ref_mem[7'h41] = 16'h1234;
        do_reset;
        Start = 1'b1;
        do_instr(0, 16'h0000, 16'h0000, 1'b0);
        do_instr(1, 16'h0000, 16'h0000, 1'b0);
        do_instr(1, 16'hFF40, 16'h0BEE, 1'b0);
        do_instr(2, 16'h0041, 16'h0000, 1'b0);
        do_instr(0, 16'h0000, 16'h0000, 1'b0);
        checks++;
        if (!halt_seen) begin
            errors++;
            $display("FAIL halt_reached: halt not reached, required halt at pc=5");
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            proc_done = 1'b0;
            checks++;
            if (halted !== 1'b1 || proc_run !== 1'b0 || pc !== 7'd5) begin
                errors++;
                $display("FAIL halt_hold: halted=%b run=%b pc=%0d, required 1 0 5", halted, proc_run, pc);
            end
        end
        checks++;
        if (ram[7'h40] !== 16'h0BEE) begin
            errors++;
            $display("FAIL sd_ram: ram[40]=%h required 0bee", ram[7'h40]);
        end
        Start = 1'b0;
        #2 Resetn = 1'b0;
        #1;
        checks++;
        if (pc !== 7'd0 || halted !== 1'b0 || proc_run !== 1'b0 || mem_addr !== 7'd0) begin
            errors++;
            $display("FAIL halt_reset: pc=%0d halted=%b run=%b addr=%0d, required 0 0 0 0",
                     pc, halted, proc_run, mem_addr);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        exp_pc = 7'd0;
        @(negedge Clock);
        checks++;
        if (proc_run !== 1'b0 || pc !== 7'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: run=%b pc=%0d halted=%b, required 0 0 0", proc_run, pc, halted);
        end
        $display("halt and reset done pc=%0d", pc);
    endtask

    // PC wrap 127 -> 0 for a plain instruction, then an mvi at 127.
    task automatic test_wrap;
        for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0080;
        do_reset;
        Start = 1'b1;
        for (int n = 0; n < 128; n++) do_instr(0, 16'h0, 16'h0, 1'b0);
        @(negedge Clock);
        proc_done = 1'b0;
        checks++;
        if (pc !== 7'd0) begin
            errors++;
            $display("FAIL wrap_plain: pc=%0d required 0", pc);
        end
        ref_mem[127] = 16'h0021;
        do_reset;
        Start = 1'b1;
        for (int n = 0; n < 128; n++) do_instr(0, 16'h0, 16'h0, 1'b0);
        @(negedge Clock);
        proc_done = 1'b0;
        checks++;
        if (pc !== 7'd1 || exp_pc !== 7'd1) begin
            errors++;
            $display("FAIL wrap_mvi: pc=%0d required 1", pc);
        end
    endtask

    // Asynchronous reset in the middle of EXEC aborts the instruction.
    task automatic test_abort;
        for (int i = 0; i < 128; i++) ref_mem[i] = 16'h0080;
        do_reset;
        Start = 1'b1;
        do_instr(0, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            proc_done = 1'b0;
        end
        checks++;
        if (proc_run !== 1'b1 || pc !== 7'd1) begin
            errors++;
            $display("FAIL abort_setup: run=%b pc=%0d, required run=1 pc=1", proc_run, pc);
        end
        Start = 1'b0;
        #2 Resetn = 1'b0;
        #1;
        checks++;
        if (proc_run !== 1'b0 || pc !== 7'd0 || proc_din !== 16'h0) begin
            errors++;
            $display("FAIL abort_reset: run=%b pc=%0d din=%h, required 0 0 0000", proc_run, pc, proc_din);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        exp_pc = 7'd0;
        $display("abort reset pc=%0d run=%b", pc, proc_run);
    endtask

    // Random programs (no HALT words) with random proc timing, addresses and
    // occasional Start drops.
    task automatic test_random;
        logic [15:0] w, pa, wd;
        int          dly;
        bit          drop;
        for (int i = 0; i < 128; i++) begin
            w = 16'($urandom);
            if (w[3:0] == 4'hF) w[3:0] = 4'($urandom_range(0, 14));
            ref_mem[i] = w;
        end
        do_reset;
        Start = 1'b1;
        for (int n = 0; n < 200; n++) begin
            dly  = $urandom_range(0, 3);
            pa   = 16'($urandom);
            wd   = 16'($urandom);
            if (wd[3:0] == 4'hF) wd[3:0] = 4'h0;
            drop = ($urandom_range(0, 7) == 0);
            do_instr(dly, pa, wd, drop);
            if (drop) begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge Clock);
                    proc_done = 1'b0;
                    checks++;
                    if (proc_run !== 1'b0 || pc !== exp_pc || mem_addr !== exp_pc) begin
                        errors++;
                        $display("FAIL start_drop_idle: run=%b pc=%0d addr=%0d, required run=0 pc=addr=%0d",
                                 proc_run, pc, mem_addr, exp_pc);
                    end
                end
                $display("idle pc=%0d", pc);
                Start = 1'b1;
            end
        end
    endtask

    initial begin
        Resetn     = 1'b0;
        Start      = 1'b0;
        proc_done  = 1'b0;
        proc_store = 1'b0;
        proc_addr  = 16'h0;
        wdata      = 16'h0;
        exp_pc     = 7'd0;
        test_reset;
        test_program;
        test_wrap;
        test_abort;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
